// File: rtl/scanner_serial_tx_pkg.sv
// Shared state, command and slot-code definitions for the scanner serial transmitter.
// Status codes are one byte each and go out on the slot-framed serial stream.
package scanner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCANNING,
        WAIT_READY,
        SEND_HDR,
        SEND_DATA
    } state_t;

    localparam logic [7:0] CODE_IDLE  = 8'd0;
    localparam logic [7:0] CODE_50    = 8'd1;
    localparam logic [7:0] CODE_80    = 8'd2;
    localparam logic [7:0] CODE_90    = 8'd3;
    localparam logic [7:0] CODE_FULL  = 8'd4;
    localparam logic [7:0] CODE_FLUSH = 8'd5;
    localparam logic [7:0] CODE_READY = 8'd6;
    localparam logic [7:0] CODE_BIN   = 8'd7;
    localparam logic [7:0] CODE_ASCII = 8'd8;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_SCAN  = 2'b01;
    localparam logic [1:0] CMD_FLUSH = 2'b10;

    // Only the most urgent pending status is worth a slot; the rest are dropped.
    function automatic logic [7:0] status_byte(input logic [4:1] pend);
        logic [7:0] code;
        code = CODE_IDLE;
        if (pend[4])      code = CODE_FULL;
        else if (pend[3]) code = CODE_90;
        else if (pend[2]) code = CODE_80;
        else if (pend[1]) code = CODE_50;
        return code;
    endfunction

endpackage

// File: rtl/scanner_serial_tx_if.sv
// Scanner-side bundle: transfer-center command, sample input, serial output and status.
// slave is the transmitter's view, master is the driver/observer's view.
interface scanner_serial_tx_if #(parameter int DEPTH = 10);
    localparam int FW = $clog2(DEPTH + 1);

    logic [1:0]    scannerCmd;
    logic          readyForTransferIn;
    logic          sampleValid;
    logic [7:0]    sampleData;
    logic          dataOut;
    logic          scanning;
    logic          transferring;
    logic [FW-1:0] fillLevel;
    logic          overflow;

    modport master (
        output scannerCmd, readyForTransferIn, sampleValid, sampleData,
        input  dataOut, scanning, transferring, fillLevel, overflow
    );

    modport slave (
        input  scannerCmd, readyForTransferIn, sampleValid, sampleData,
        output dataOut, scanning, transferring, fillLevel, overflow
    );
endinterface

// File: rtl/scanner_serial_tx_fifo.sv
// Circular sample buffer; dout is the head entry combinationally, count updates one cycle after push/pop.
// No internal guarding: the caller never pushes when full or pops when empty.
module scan_fifo #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/scanner_serial_tx.sv
// Scanner buffer + status FSM serialising one byte per 8-cycle slot, MSB first, slot locked to reset.
// No backpressure on samples: they are dropped outside SCANNING; transfers start only when readyForTransferIn is high at a slot boundary.
module scanner_serial_tx #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    scanner_serial_tx_if.slave   bus
);
    import scanner_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] T50 = CW'(DEPTH / 2);
    localparam logic [CW-1:0] T80 = CW'(DEPTH * 8 / 10);
    localparam logic [CW-1:0] T90 = CW'(DEPTH * 9 / 10);
    localparam logic [CW-1:0] TF  = CW'(DEPTH);

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_byte;
    logic [CW-1:0]    xfer_cnt;
    logic [4:1]       pending;
    logic [4:1]       new_flags;
    logic             hit_full;
    logic             scanning_q;
    logic             transferring_q;
    logic             overflow_q;
    logic             boundary;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_inc;
    logic [WIDTH-1:0] head;
    logic [7:0]       status_code;

    assign boundary    = (bit_cnt == 3'd7);
    assign push        = (state == SCANNING) && bus.sampleValid && (count != TF);
    assign pop         = boundary && ((state == SEND_HDR) || (state == SEND_DATA)) && (xfer_cnt != '0);
    assign count_inc   = count + CW'(1);
    assign status_code = status_byte(pending);

    always_comb begin
        new_flags = '0;
        if (push) begin
            new_flags[1] = (count_inc == T50);
            new_flags[2] = (count_inc == T80);
            new_flags[3] = (count_inc == T90);
            new_flags[4] = (count_inc == TF);
        end
    end

    scan_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.sampleData),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            tx_byte        <= '0;
            xfer_cnt       <= '0;
            pending        <= '0;
            hit_full       <= 1'b0;
            scanning_q     <= 1'b0;
            transferring_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            pending <= pending | new_flags;
            if (push && (count_inc == TF)) hit_full <= 1'b1;
            if (bus.sampleValid && hit_full && (state inside {WAIT_READY, SEND_HDR, SEND_DATA}))
                overflow_q <= 1'b1;

            // Default slot content; header and data slots override it below.
            if (boundary) begin
                tx_byte <= status_code;
                if (pending != '0) pending <= new_flags;
            end

            case (state)
                IDLE: begin
                    if (bus.scannerCmd == CMD_SCAN) begin
                        state      <= SCANNING;
                        scanning_q <= 1'b1;
                    end else if ((bus.scannerCmd == CMD_FLUSH) && (count != '0)) begin
                        state <= WAIT_READY;
                    end
                end
                SCANNING: begin
                    if ((push && (count_inc == TF)) || (bus.scannerCmd == CMD_FLUSH)) begin
                        state      <= WAIT_READY;
                        scanning_q <= 1'b0;
                    end
                end
                WAIT_READY: begin
                    if (boundary && bus.readyForTransferIn) begin
                        state          <= SEND_HDR;
                        transferring_q <= 1'b1;
                        xfer_cnt       <= count;
                        tx_byte        <= CODE_BIN;
                        pending        <= '0;
                    end
                end
                SEND_HDR, SEND_DATA: begin
                    if (boundary) begin
                        if (xfer_cnt != '0) begin
                            state    <= SEND_DATA;
                            tx_byte  <= head;
                            xfer_cnt <= xfer_cnt - CW'(1);
                        end else begin
                            state          <= IDLE;
                            transferring_q <= 1'b0;
                            hit_full       <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dataOut      = tx_byte[3'd7 - bit_cnt];
    assign bus.scanning     = scanning_q;
    assign bus.transferring = transferring_q;
    assign bus.fillLevel    = count;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_scanner_serial_tx.sv
// Directed bench for scanner_serial_tx: slot timing is tracked by counting edges since reset release.
module tb_scanner_serial_tx;
    import scanner_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    scanner_serial_tx_if #(.DEPTH(10)) bus();

    scanner_serial_tx #(.DEPTH(10), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int ncmp = 0;
    int nerr = 0;
    int k    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        while ((k % 8) != 0) tick();
    endtask

    task automatic rx_byte(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        align();
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b = {b[6:0], bus.dataOut};
            tick();
        end
        chk(tag, 32'(b), 32'(exp));
    endtask

    task automatic drive_sample(input logic [7:0] d);
        bus.sampleValid = 1'b1;
        bus.sampleData  = d;
        tick();
        bus.sampleValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.scannerCmd         = CMD_NONE;
        bus.readyForTransferIn = 1'b0;
        bus.sampleValid        = 1'b0;
        bus.sampleData         = 8'h00;

        #1;
        chk("rst_dataOut", 32'(bus.dataOut), 0);
        chk("rst_fill", 32'(bus.fillLevel), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_scanning", 32'(bus.scanning), 0);
        chk("rst_transferring", 32'(bus.transferring), 0);
        tick();
        tick();
        rst = 1'b1;
        k   = 0;
        for (int i = 0; i < 16; i++) begin
            chk("idle_bit", 32'(bus.dataOut), 0);
            tick();
        end

        // Short scan, flush with a simultaneous last sample, then transfer.
        bus.scannerCmd = CMD_SCAN;
        tick();
        bus.scannerCmd = CMD_NONE;
        drive_sample(8'hB0);
        drive_sample(8'hB1);
        bus.scannerCmd = CMD_FLUSH;
        drive_sample(8'hB2);
        bus.scannerCmd = CMD_NONE;
        chk("flush_scanning", 32'(bus.scanning), 0);
        chk("flush_fill", 32'(bus.fillLevel), 3);
        drive_sample(8'hEE);
        chk("drop_fill", 32'(bus.fillLevel), 3);
        chk("no_overflow_below_full", 32'(bus.overflow), 0);
        align();
        bus.readyForTransferIn = 1'b1;
        rx_byte("wait_slot_idle", 8'h00);
        chk("hdr_transferring", 32'(bus.transferring), 1);
        rx_byte("small_hdr", CODE_BIN);
        bus.readyForTransferIn = 1'b0;
        rx_byte("small_d0", 8'hB0);
        rx_byte("small_d1", 8'hB1);
        rx_byte("small_d2", 8'hB2);
        chk("small_done_fill", 32'(bus.fillLevel), 0);
        chk("small_done_transferring", 32'(bus.transferring), 0);
        rx_byte("small_after_idle", 8'h00);

        // Flush with an empty buffer must not start a transfer.
        bus.scannerCmd         = CMD_FLUSH;
        bus.readyForTransferIn = 1'b1;
        tick();
        bus.scannerCmd = CMD_NONE;
        align();
        chk("empty_flush_transferring", 32'(bus.transferring), 0);
        rx_byte("empty_flush_slot", 8'h00);
        bus.readyForTransferIn = 1'b0;

        // Half-full status code.
        bus.scannerCmd = CMD_SCAN;
        tick();
        bus.scannerCmd = CMD_NONE;
        for (int i = 0; i < 5; i++) drive_sample(8'hA0 + 8'(i));
        chk("half_scanning", 32'(bus.scanning), 1);
        chk("half_fill", 32'(bus.fillLevel), 5);
        rx_byte("code_50", CODE_50);

        // 80/90/full crossings inside one slot: only the full code is sent.
        for (int i = 5; i < 10; i++) drive_sample(8'hA0 + 8'(i));
        chk("full_scanning", 32'(bus.scanning), 0);
        chk("full_fill", 32'(bus.fillLevel), 10);
        rx_byte("code_full", CODE_FULL);
        rx_byte("lower_codes_dropped", 8'h00);
        drive_sample(8'hEE);
        chk("overflow_set", 32'(bus.overflow), 1);
        chk("overflow_fill", 32'(bus.fillLevel), 10);

        // Full transfer, ready dropped right after it starts.
        tick();
        tick();
        tick();
        bus.readyForTransferIn = 1'b1;
        align();
        bus.readyForTransferIn = 1'b0;
        chk("full_hdr_transferring", 32'(bus.transferring), 1);
        rx_byte("full_hdr", CODE_BIN);
        chk("first_pop_fill", 32'(bus.fillLevel), 9);
        for (int i = 0; i < 10; i++) rx_byte("full_data", 8'hA0 + 8'(i));
        chk("full_done_fill", 32'(bus.fillLevel), 0);
        chk("full_done_transferring", 32'(bus.transferring), 0);
        chk("full_done_scanning", 32'(bus.scanning), 0);
        rx_byte("full_after_idle", 8'h00);

        // Reset in the middle of a data slot.
        bus.scannerCmd = CMD_SCAN;
        tick();
        bus.scannerCmd = CMD_NONE;
        drive_sample(8'h3C);
        drive_sample(8'h81);
        bus.scannerCmd         = CMD_FLUSH;
        bus.readyForTransferIn = 1'b1;
        tick();
        bus.scannerCmd = CMD_NONE;
        repeat (15) tick();
        chk("pre_reset_bit", 32'(bus.dataOut), 1);
        chk("pre_reset_transferring", 32'(bus.transferring), 1);
        rst = 1'b0;
        #1;
        chk("midrst_dataOut", 32'(bus.dataOut), 0);
        chk("midrst_fill", 32'(bus.fillLevel), 0);
        chk("midrst_transferring", 32'(bus.transferring), 0);
        chk("midrst_overflow", 32'(bus.overflow), 0);
        bus.readyForTransferIn = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        k   = 0;
        for (int i = 0; i < 16; i++) begin
            chk("post_rst_bit", 32'(bus.dataOut), 0);
            tick();
        end
        chk("post_rst_fill", 32'(bus.fillLevel), 0);
        chk("post_rst_scanning", 32'(bus.scanning), 0);
        chk("post_rst_transferring", 32'(bus.transferring), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/scanner_serial_tx.md
Name: scanner_serial_tx

Overview:
- Upstream neighbour of the transfer-center receiver.
- Models the local scanner's sample buffer and status logic.
- Serializes status codes and buffered scan data onto the one-bit byte stream that the transfer center deserializes.
- Byte framing is locked to a free-running 3-bit bit counter that starts at reset, so the receiver's own byte counter stays slot-aligned.

Parameters:
- DEPTH, 10, buffer entries; status thresholds are derived from it.
- WIDTH, 8, bits per sample and per serial byte; fixed at 8 for the stream protocol.

Ports:
- clk  input  1  system clock; all state is updated on posedge.
- rst  input  1  asynchronous active-low reset.
- scannerCmd  input  2  from transfer center: 00 none, 01 start scan, 10 flush.
- readyForTransferIn  input  1  downstream permission to send buffered data.
- sampleValid  input  1  a sample is presented this cycle.
- sampleData  input  8  sample value.
- dataOut  output  1  serial stream, MSB first.
- scanning  output  1  high in state SCANNING.
- transferring  output  1  high in state SEND_HDR or SEND_DATA.
- fillLevel  output  $clog2(DEPTH+1)  current buffer occupancy.
- overflow  output  1  sticky flag: a sample was dropped because the buffer was full.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, bitCnt=0, txByte=0, dataOut=0.
  - fillLevel=0, overflow=0, all pending-status flags clear.
  - Applies immediately, including mid-transfer; the partial byte is abandoned.
- Framing:
  - bitCnt increments every cycle and wraps 7->0.
  - dataOut = txByte[7-bitCnt], so the MSB goes out on the cycle with bitCnt=0.
  - txByte is reloaded only on the edge where bitCnt wraps 7->0 (slot boundary).
- Slot byte selection at each boundary, highest priority first:
  - SEND_DATA: next buffer entry (popped).
  - SEND_HDR: 8'd7 (binary data follows).
  - Otherwise, highest pending status code: 4 > 3 > 2 > 1.
  - Otherwise 8'd0 (idle).
  - When a status code is sent, all pending flags clear; lower codes are dropped.
- Thresholds, integer arithmetic: T50=DEPTH/2, T80=DEPTH*8/10, T90=DEPTH*9/10, TF=DEPTH (5/8/9/10 at default).
  - A status flag sets only on the cycle fillLevel transitions to equal its threshold: code 1/2/3/4 respectively.
- State machine:
  - IDLE:
    - cmd 01 -> SCANNING.
    - cmd 10 with fillLevel>0 -> WAIT_READY.
    - cmd 10 with fillLevel=0 is ignored.
  - SCANNING:
    - sampleValid pushes sampleData; fillLevel increments the next cycle.
    - Reaching TF -> WAIT_READY.
    - cmd 10 -> WAIT_READY. A simultaneous sampleValid is still written first.
    - cmd 01 is ignored.
  - WAIT_READY:
    - If readyForTransferIn=1 at a slot boundary: snapshot count=fillLevel -> SEND_HDR.
    - Pending flags clear at the moment of leaving this state.
  - SEND_HDR: exactly one slot, then -> SEND_DATA.
  - SEND_DATA:
    - Sends entries in FIFO order, one per slot, for count slots.
    - After the last slot -> IDLE with fillLevel=0.
    - readyForTransferIn deasserting mid-transfer is ignored; the transfer completes.
- sampleValid outside SCANNING:
  - Dropped.
  - overflow sets only if it arrives while in WAIT_READY/SEND_* after the buffer reached TF.
- scannerCmd is ignored in SEND_HDR/SEND_DATA.
- Commands are level-sampled each cycle; no edge detection.

Decomposition:
- Package scanner_pkg holds:
  - state enum {IDLE, SCANNING, WAIT_READY, SEND_HDR, SEND_DATA}.
  - Codes CODE_IDLE=0, CODE_50=1, CODE_80=2, CODE_90=3, CODE_FULL=4, CODE_FLUSH=5, CODE_READY=6, CODE_BIN=7, CODE_ASCII=8.
  - Command encodings CMD_NONE/CMD_SCAN/CMD_FLUSH.
- Sub-module scan_fifo:
  - Circular DEPTH x WIDTH buffer with push, pop, dout, count.
  - Pointers wrap at DEPTH-1 -> 0.

Test Plan:
- Reset release, then 16 idle cycles -> dataOut=0 throughout; bitCnt wraps at cycles 8 and 16.
- cmd 01, then 5 samples -> next slot carries 8'h01, seen as serial 0,0,0,0,0,0,0,1.
- 10 consecutive samples with no slot boundary between the 8 and 9 crossings -> only the highest pending code is sent (3 or 4); scanning drops to 0 at fill 10.
- Full buffer with readyForTransferIn=0 for 20 cycles, then 1 -> next boundary sends 8'h07, then samples 0xA0..0xA9 in order; fillLevel=0 afterwards; state IDLE.
- 3 samples, then cmd 10, ready=1 -> header 7 plus 3 data bytes; 11th sample pushed into a full buffer -> overflow=1.
- rst asserted mid SEND_DATA (bitCnt=3) -> dataOut=0 immediately; after release, idle bytes only and fillLevel=0.
